// File: rtl/dac_cmd_queue_pkg.sv
// Shared types for the DAC command queue: command word layout and sequencer states.
package dac_pkg;

  localparam int CMD_W = 24;

  typedef struct packed {
    logic [3:0]  comm;
    logic [3:0]  addr;
    logic [15:0] data;
  } dac_cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STROBE,
    WAIT_START,
    WAIT_DONE,
    GAP
  } seq_state_t;

endpackage

// File: rtl/dac_cmd_queue_fifo.sv
// Synchronous command FIFO with occupancy level; a push while full is ignored.
module dac_cmd_fifo
  import dac_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  dac_cmd_t               wr_cmd,
  output dac_cmd_t               rd_cmd,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign rd_cmd  = dac_cmd_t'(mem[rd_ptr]);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_cmd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/dac_cmd_queue.sv
// DAC command queue and sequencer feeding the SPI serializer one command per frame.
// Optional DAC_CMD_COUNT_EN adds a 16-bit wrapping strobe counter output tx_count.
module dac_cmd_queue
  import dac_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int GAP_CYC = 64,
  parameter int TMO_CYC = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [3:0]             wr_comm,
  input  logic [3:0]             wr_addr,
  input  logic [15:0]            wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  input  logic                   init_done,
  input  logic                   spi_busy,
  output logic [3:0]             comm,
  output logic [3:0]             addr,
  output logic [15:0]            data,
  output logic                   ext_ctrl,
  output logic                   overflow,
  output logic                   err_timeout,
  input  logic                   clr_err
`ifdef DAC_CMD_COUNT_EN
  ,
  output logic [15:0]            tx_count
`endif
);

  localparam int CNT_MAX = (TMO_CYC > GAP_CYC) ? TMO_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             tmo_hit;
  dac_cmd_t         wr_cmd;
  dac_cmd_t         head;
  dac_cmd_t         cmd_q;

  assign wr_cmd = '{comm: wr_comm, addr: wr_addr, data: wr_data};

  dac_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (wr_en),
    .pop    (ext_ctrl),
    .wr_cmd (wr_cmd),
    .rd_cmd (head),
    .full   (full),
    .empty  (empty),
    .level  (level)
  );

  always_comb begin
    state_nxt = state;
    tmo_hit   = 1'b0;
    unique case (state)
      IDLE:       if (!empty && init_done && !spi_busy) state_nxt = LOAD;
      LOAD:       state_nxt = STROBE;
      STROBE:     state_nxt = WAIT_START;
      WAIT_START: begin
        if (spi_busy) begin
          state_nxt = WAIT_DONE;
        end else if (cnt == TMO_LAST) begin
          tmo_hit   = 1'b1;
          state_nxt = GAP;
        end
      end
      WAIT_DONE:  if (!spi_busy) state_nxt = GAP;
      GAP:        if (cnt == GAP_LAST) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  assign ext_ctrl = (state == STROBE);
  assign comm     = cmd_q.comm;
  assign addr     = cmd_q.addr;
  assign data     = cmd_q.data;

  // cnt restarts on every state change so WAIT_START and GAP each time from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      cmd_q       <= '0;
      overflow    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state || state == IDLE) ? '0 : cnt + 1'b1;
      if (state == LOAD) cmd_q <= head;
      if (clr_err) begin
        overflow    <= 1'b0;
        err_timeout <= 1'b0;
      end else begin
        if (wr_en && full) overflow <= 1'b1;
        if (tmo_hit)       err_timeout <= 1'b1;
      end
    end
  end

`ifdef DAC_CMD_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               tx_count <= '0;
    else if (state == STROBE) tx_count <= tx_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_dac_cmd_queue.sv
// Scoreboard bench for dac_cmd_queue with a cycle-level serializer busy model.
module tb_dac_cmd_queue;

  localparam int DEPTH = 8;
  localparam int GAP   = 8;
  localparam int TMO   = 40;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic                   wr_en = 1'b0;
  logic [3:0]             wr_comm = '0;
  logic [3:0]             wr_addr = '0;
  logic [15:0]            wr_data = '0;
  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH):0] level;
  logic                   init_done = 1'b0;
  logic                   spi_busy = 1'b0;
  logic [3:0]             comm;
  logic [3:0]             addr;
  logic [15:0]            data;
  logic                   ext_ctrl;
  logic                   overflow;
  logic                   err_timeout;
  logic                   clr_err = 1'b0;
`ifdef DAC_CMD_COUNT_EN
  logic [15:0]            tx_count;
`endif

  dac_cmd_queue #(
    .DEPTH   (DEPTH),
    .GAP_CYC (GAP),
    .TMO_CYC (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_comm     (wr_comm),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .full        (full),
    .empty       (empty),
    .level       (level),
    .init_done   (init_done),
    .spi_busy    (spi_busy),
    .comm        (comm),
    .addr        (addr),
    .data        (data),
    .ext_ctrl    (ext_ctrl),
    .overflow    (overflow),
    .err_timeout (err_timeout),
    .clr_err     (clr_err)
`ifdef DAC_CMD_COUNT_EN
    ,
    .tx_count    (tx_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: accepted commands in order, occupancy, sticky flags, last issued command.
  logic [23:0] exp_q[$];
  int          mcount = 0;
  bit          m_ovf = 1'b0;
  bit          m_err = 1'b0;
  logic [23:0] m_cmd = '0;
  int          tmo_due = -1;
  int          strobe_cnt = 0;
  int          last_strobe_cyc = -1;
  bit          init_h1 = 1'b0;
  bit          init_h2 = 1'b0;
  int          tx_model = 0;

  // Busy-model controls owned by the stimulus process.
  bit no_busy_mode = 1'b0;
  int lat_fix = 0;
  int len_fix = 0;
  int rst_gen = 0;

  // Serializer model state.
  int bm_seen = 0;
  int bm_rst_seen = 0;
  int bm_phase = 0;
  int bm_cnt = 0;
  int fall_cyc = -1;

  always @(negedge clk) begin
    bit push;
    bit pop;
    int old_count;
    if (!rst_n) begin
      exp_q.delete();
      mcount = 0;
      m_ovf = 1'b0;
      m_err = 1'b0;
      m_cmd = '0;
      tmo_due = -1;
      tx_model = 0;
      init_h1 = 1'b0;
      init_h2 = 1'b0;
      last_strobe_cyc = -1;
    end
    chk("level", level, mcount);
    chk("full", full, mcount == DEPTH);
    chk("empty", empty, mcount == 0);
    chk("overflow", overflow, m_ovf);
    chk("err_timeout", err_timeout, m_err);
`ifdef DAC_CMD_COUNT_EN
    chk("tx_count", tx_count, tx_model);
`endif
    if (ext_ctrl) begin
      strobe_cnt++;
      if (exp_q.size() == 0) begin
        chk("strobe_unexpected", 1, 0);
      end else begin
        m_cmd = exp_q.pop_front();
        chk("strobe_init_ok", init_h2, 1);
        if (fall_cyc > last_strobe_cyc)
          chk("gap_after_busy", (cyc - fall_cyc) >= GAP + 1, 1);
        if (no_busy_mode) tmo_due = cyc + 1 + TMO;
      end
      last_strobe_cyc = cyc;
      tx_model = (tx_model + 1) & 16'hFFFF;
    end
    chk("cmd_out", {comm, addr, data}, m_cmd);
    old_count = mcount;
    push = wr_en && (old_count < DEPTH);
    pop  = ext_ctrl && (old_count > 0);
    mcount = old_count + int'(push) - int'(pop);
    if (clr_err) m_ovf = 1'b0;
    else if (wr_en && old_count == DEPTH) m_ovf = 1'b1;
    if (clr_err) m_err = 1'b0;
    else if (cyc + 1 == tmo_due) m_err = 1'b1;
    init_h2 = init_h1;
    init_h1 = init_done;
  end

  always @(posedge clk) begin
    #1;
    if (rst_gen != bm_rst_seen) begin
      bm_rst_seen = rst_gen;
      bm_phase = 0;
      spi_busy = 1'b0;
      bm_seen = strobe_cnt;
    end else begin
      if (strobe_cnt != bm_seen) begin
        bm_seen = strobe_cnt;
        if (!no_busy_mode) begin
          bm_phase = 1;
          bm_cnt = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 6));
        end
      end
      if (bm_phase == 1) begin
        bm_cnt--;
        if (bm_cnt == 0) begin
          spi_busy = 1'b1;
          bm_phase = 2;
          bm_cnt = (len_fix > 0) ? len_fix : int'($urandom_range(1, 12));
        end
      end else if (bm_phase == 2) begin
        bm_cnt--;
        if (bm_cnt == 0) begin
          spi_busy = 1'b0;
          fall_cyc = cyc;
          bm_phase = 0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [23:0] c);
    wr_en = 1'b1;
    {wr_comm, wr_addr, wr_data} = c;
    if (mcount < DEPTH) exp_q.push_back(c);
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic wait_strobes(input int target, input int limit, input string name);
    for (int i = 0; i < limit; i++) begin
      if (strobe_cnt >= target) break;
      tick(1);
    end
    if (strobe_cnt < target) chk(name, strobe_cnt, target);
  endtask

  task automatic drain(input int limit, input int settle);
    for (int i = 0; i < limit; i++) begin
      if (exp_q.size() == 0) break;
      tick(1);
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    tick(settle);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int r;
    int s0;
    int t1;
    #2 rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // No issue while init_done is low; issue two cycles after it rises.
    write({4'h3, 4'h1, 16'hABCD});
    tick(20);
    chk("no_strobe_without_init", strobe_cnt, 0);
    init_done = 1'b1;
    r = cyc;
    wait_strobes(1, 50, "init_strobe_timeout");
    chk("init_to_strobe_latency", last_strobe_cyc - r, 2);
    drain(100, 40);

    // Three commands with busy rising 20 cycles after strobe, lasting 50.
    lat_fix = 20;
    len_fix = 50;
    s0 = strobe_cnt;
    for (int i = 0; i < 3; i++) write(24'($urandom));
    drain(600, 20 + 50 + GAP + 6);
    chk("three_strobes", strobe_cnt - s0, 3);
    lat_fix = 0;
    len_fix = 0;

    // Fill to DEPTH, one extra write is dropped and sets overflow.
    init_done = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) write(24'($urandom));
    chk("overflow_after_extra", overflow, 1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("overflow_cleared", overflow, 0);
    init_done = 1'b1;
    drain(2000, 40);

    // Serializer never starts: exact timeout, then next command after the gap.
    no_busy_mode = 1'b1;
    s0 = strobe_cnt;
    write(24'h5A_1234);
    write(24'h6B_5678);
    wait_strobes(s0 + 1, 50, "tmo_first_strobe");
    t1 = last_strobe_cyc;
    wait_strobes(s0 + 2, TMO + GAP + 20, "tmo_second_strobe");
    chk("tmo_strobe_spacing", last_strobe_cyc - t1, TMO + GAP + 3);
    drain(10, TMO + GAP + 10);
    chk("err_timeout_set", err_timeout, 1);
    no_busy_mode = 1'b0;
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("err_timeout_cleared", err_timeout, 0);

    // Random traffic, random init_done dips and clears, overlapping push/pop.
    for (int i = 0; i < 120; i++) begin
      clr_err = ($urandom_range(0, 19) == 0);
      init_done = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 2) != 0) write(24'($urandom));
      else tick(1);
      clr_err = 1'b0;
    end
    init_done = 1'b1;
    drain(3000, 40);

    // Reset during WAIT_DONE with two commands still queued.
    lat_fix = 3;
    len_fix = 40;
    for (int i = 0; i < 3; i++) write(24'($urandom));
    for (int i = 0; i < 100; i++) begin
      if (spi_busy) break;
      tick(1);
    end
    chk("busy_before_reset", spi_busy, 1);
    tick(2);
    chk("queued_before_reset", level, 2);
    rst_n = 1'b0;
    rst_gen++;
    tick(1);
    chk("reset_ext_ctrl", ext_ctrl, 0);
    chk("reset_cmd", {comm, addr, data}, 0);
    chk("reset_empty", empty, 1);
    tick(2);
    rst_n = 1'b1;
    lat_fix = 0;
    len_fix = 0;
    s0 = strobe_cnt;
    tick(40);
    chk("no_strobe_after_reset", strobe_cnt - s0, 0);
    write(24'h9C_0F0F);
    wait_strobes(s0 + 1, 20, "post_reset_strobe");
    drain(100, 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
